// File: rtl/dsc_mul_nway.sv
// N-way stochastic (digit-stream) multiplier.
// Each operand i becomes a unary stream bit s[i] = (op[i] > ctr[i]). The
// counters form a clock-enabled odometer, so every combination of counter
// values is visited exactly once per run. Counting the cycles in which all
// stream bits are 1 therefore gives the exact integer product of the operands.
//
// Handshake: start is a request that is sampled only in IDLE. It is accepted
// on the edge where state==IDLE and start==1, and the operands are captured on
// that same edge. busy is high from the next cycle until the block returns to
// IDLE. done is a single-cycle pulse, and z holds the result until the next
// accepted start.
module dsc_mul_nway #(
  parameter int WIDTH      = 8,
  parameter int NUM_IN     = 3,
  parameter int EARLY_EXIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_IN*WIDTH-1:0] operands,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_IN*WIDTH-1:0] z
);

  localparam int ZW = NUM_IN * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_q [NUM_IN];
  logic [WIDTH-1:0] ctr  [NUM_IN];
  logic [ZW-1:0]    acc;

  logic [NUM_IN-1:0] s;
  logic [NUM_IN-1:0] ctr_max;
  logic [NUM_IN-1:0] ctr_en;
  logic              p;
  logic              last;
  logic              any_zero;

  // Stream bits, product bit, odometer carry chain and run-termination flags.
  always_comb begin
    s         = '0;
    ctr_max   = '0;
    ctr_en    = '0;
    any_zero  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      s[i]       = (op_q[i] > ctr[i]);
      ctr_max[i] = &ctr[i];
      any_zero   = any_zero | (op_q[i] == '0);
    end
    ctr_en[0] = 1'b1;
    for (int i = 1; i < NUM_IN; i++) begin
      ctr_en[i] = ctr_en[i-1] & ctr_max[i-1];
    end
    p    = &s;
    last = &ctr_max;
  end

  // Control FSM with registered outputs, operand latch, counters and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      acc   <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        op_q[i] <= '0;
        ctr[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < NUM_IN; i++) begin
              op_q[i] <= operands[i*WIDTH +: WIDTH];
              ctr[i]  <= '0;
            end
            acc   <= '0;
            z     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if ((EARLY_EXIT != 0) && any_zero) begin
            // A zero factor forces a zero product, so the sweep is skipped.
            z     <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc <= acc + ZW'(p);
            for (int i = 0; i < NUM_IN; i++) begin
              if (ctr_en[i]) ctr[i] <= ctr[i] + 1'b1;
            end
            if (last) begin
              // Include this final cycle's product bit in the published result.
              z     <= acc + ZW'(p);
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_nway.sv
// Bench for dsc_mul_nway: six WIDTH=2 instances covering NUM_IN 2/3/4 with
// EARLY_EXIT on and off. Expected products and latencies come from plain
// arithmetic on the operand fields.
module tb_dsc_mul_nway;

  localparam int NCFG = 6;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0] rst;
  logic [NCFG-1:0] start;
  logic [NCFG-1:0] busy;
  logic [NCFG-1:0] done;
  logic [7:0]      ops   [NCFG];
  logic [7:0]      z_all [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int N = (g < 2) ? 3 : ((g < 4) ? 2 : 4);
    localparam int E = (g % 2 == 0) ? 1 : 0;
    logic [N*2-1:0] zw;
    dsc_mul_nway #(.WIDTH(2), .NUM_IN(N), .EARLY_EXIT(E)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .operands (ops[g][N*2-1:0]),
      .busy     (busy[g]),
      .done     (done[g]),
      .z        (zw)
    );
    assign z_all[g] = 8'(zw);
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nin(input int k);
    return (k < 2) ? 3 : ((k < 4) ? 2 : 4);
  endfunction

  function automatic bit early(input int k);
    return (k % 2) == 0;
  endfunction

  function automatic int model_prod(input int k, input logic [7:0] v);
    int prod;
    prod = 1;
    for (int i = 0; i < nin(k); i++) prod = prod * int'((v >> (2*i)) & 8'h3);
    return prod;
  endfunction

  function automatic int model_lat(input int k, input logic [7:0] v);
    bit has_zero;
    has_zero = 1'b0;
    for (int i = 0; i < nin(k); i++)
      if (((v >> (2*i)) & 8'h3) == 0) has_zero = 1'b1;
    if (early(k) && has_zero) return 2;
    return (1 << (2 * nin(k))) + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Counts negedges (= elapsed posedges) until done; -1 if the budget expires.
  task automatic wait_done(input int k, input int first, output int lat);
    lat = first;
    while (!done[k] && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!done[k]) lat = -1;
  endtask

  task automatic run_mul(input int k, input logic [7:0] v, input string tag);
    int lat;
    int e;
    int el;
    e  = model_prod(k, v);
    el = model_lat(k, v);
    exp_q.push_back(8'(e));
    @(negedge clk);
    ops[k]   = v;
    start[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[k] = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy[k]), 1);
    chk({tag, "_z_cleared"}, int'(z_all[k]), 0);
    wait_done(k, 1, lat);
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_z"}, int'(z_all[k]), int'(exp_q.pop_front()));
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done[k]), 0);
    chk({tag, "_busy_idle"}, int'(busy[k]), 0);
    chk({tag, "_z_hold"}, int'(z_all[k]), e);
  endtask

  typedef struct {
    int         k;
    logic [7:0] v;
    int         z;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    int cnt;
    int k;
    logic [7:0] v;

    // packed op(N-1)..op0, 2 bits each
    vecs[0] = '{0, 8'h39, 6,  65};   // {3,2,1}
    vecs[1] = '{0, 8'h3F, 27, 65};   // {3,3,3}
    vecs[2] = '{0, 8'h3C, 0,  2};    // {3,3,0} early exit
    vecs[3] = '{1, 8'h3C, 0,  65};   // {3,3,0} full run
    vecs[4] = '{2, 8'h0E, 6,  17};   // {3,2}
    vecs[5] = '{2, 8'h0C, 0,  2};    // {3,0} early exit
    vecs[6] = '{3, 8'h03, 0,  17};   // {0,3} full run
    vecs[7] = '{4, 8'hBD, 18, 257};  // {2,3,3,1}
    vecs[8] = '{5, 8'h15, 0,  257};  // {0,1,1,1} full run
    vecs[9] = '{5, 8'hFF, 81, 257};  // {3,3,3,3}

    rst   = '1;
    start = '0;
    for (int i = 0; i < NCFG; i++) ops[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = '0;
    for (int i = 0; i < NCFG; i++) begin
      chk($sformatf("reset_busy_%0d", i), int'(busy[i]), 0);
      chk($sformatf("reset_done_%0d", i), int'(done[i]), 0);
      chk($sformatf("reset_z_%0d", i), int'(z_all[i]), 0);
    end

    // ---- table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_model_z", i), model_prod(vecs[i].k, vecs[i].v), vecs[i].z);
      chk($sformatf("vec%0d_model_lat", i), model_lat(vecs[i].k, vecs[i].v), vecs[i].lat);
      run_mul(vecs[i].k, vecs[i].v, $sformatf("vec%0d", i));
    end

    // ---- operand change / start during RUN, start during DONE, back-to-back ----
    @(negedge clk);
    ops[0]   = 8'h39;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    ops[0]   = 8'h3F;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 11, lat);
    chk("midrun_latency", lat, 65);
    chk("midrun_z", int'(z_all[0]), 6);
    start[0] = 1'b1;
    ops[0]   = 8'h1F;            // {1,3,3}
    @(negedge clk);
    chk("done_start_ignored_busy", int'(busy[0]), 0);
    chk("done_start_ignored_done", int'(done[0]), 0);
    @(negedge clk);              // start held through the first IDLE edge
    start[0] = 1'b0;
    chk("b2b_busy", int'(busy[0]), 1);
    wait_done(0, 1, lat);
    chk("b2b_latency", lat, 65);
    chk("b2b_z", int'(z_all[0]), 9);
    @(negedge clk);

    // ---- reset mid-RUN ----
    @(negedge clk);
    ops[1]   = 8'h3F;
    start[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[1] = 1'b0;
    repeat (19) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("abort_busy", int'(busy[1]), 0);
    chk("abort_done", int'(done[1]), 0);
    chk("abort_z", int'(z_all[1]), 0);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (done[1]) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run_mul(1, 8'h15, "after_abort");

    // ---- reset priority over start, clears a held result ----
    chk("held_z_before_rst", int'(z_all[1]), 1);
    rst[1]   = 1'b1;
    start[1] = 1'b1;
    ops[1]   = 8'h3F;
    @(negedge clk);
    rst[1]   = 1'b0;
    start[1] = 1'b0;
    chk("rst_prio_busy", int'(busy[1]), 0);
    chk("rst_prio_z", int'(z_all[1]), 0);
    @(negedge clk);
    chk("rst_prio_still_idle", int'(busy[1]), 0);

    // ---- random sweep ----
    for (int t = 0; t < 30; t++) begin
      k = $urandom_range(0, NCFG - 1);
      v = 8'($urandom_range(0, 255));
      if (nin(k) < 4) v = v & 8'((1 << (2 * nin(k))) - 1);
      run_mul(k, v, $sformatf("rand%0d_k%0d", t, k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
